// File: rtl/irq_pkg.sv
// Shared constants for the machine-mode interrupt controller: register map,
// mcause values and the request FSM states.
package irq_pkg;

  localparam logic [2:0] REG_MTIME_LO    = 3'd0;
  localparam logic [2:0] REG_MTIME_HI    = 3'd1;
  localparam logic [2:0] REG_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] REG_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] REG_MSIP        = 3'd4;
  localparam logic [2:0] REG_EXT_EN      = 3'd5;
  localparam logic [2:0] REG_EXT_PEND    = 3'd6;
  localparam logic [2:0] REG_EXT_ID      = 3'd7;

  localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
  localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
  localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

  typedef enum logic [1:0] {IDLE, REQ, ACK} irq_state_e;

endpackage

// File: rtl/irq_ctrl_if.sv
// Register port and trap-unit handshake of the interrupt controller.
// The core side (MEM stage + trap unit) is the master.
interface irq_ctrl_if;
  logic        reg_we;
  logic [2:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        trap_ack;
  logic        interrupt_req;
  logic [31:0] interrupt_cause;

  modport master (
    output reg_we, reg_addr, reg_wdata, trap_ack,
    input  reg_rdata, interrupt_req, interrupt_cause
  );

  modport slave (
    input  reg_we, reg_addr, reg_wdata, trap_ack,
    output reg_rdata, interrupt_req, interrupt_cause
  );
endinterface

// File: rtl/irq_mtimer.sv
// Machine timer: prescaled 64-bit mtime, mtimecmp and the level mtip compare.
// Half-word write strobes are decoded by the parent.
module irq_mtimer #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mtime_lo_we,
  input  logic        mtime_hi_we,
  input  logic        mtimecmp_lo_we,
  input  logic        mtimecmp_hi_we,
  input  logic [31:0] wdata,
  output logic [63:0] mtime_o,
  output logic [63:0] mtimecmp_o,
  output logic        mtip_o
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   cmp_q, cmp_d;
  logic          tick;

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    presc_d = tick ? '0 : presc_q + PW'(1);
    mtime_d = mtime_q;
    cmp_d   = cmp_q;
    if (mtime_lo_we)    mtime_d[31:0]  = wdata;
    if (mtime_hi_we)    mtime_d[63:32] = wdata;
    if (!mtime_lo_we && !mtime_hi_we && tick) mtime_d = mtime_q + 64'd1;
    if (mtimecmp_lo_we) cmp_d[31:0]    = wdata;
    if (mtimecmp_hi_we) cmp_d[63:32]   = wdata;
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      mtime_q <= '0;
      cmp_q   <= '1;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
    end
  end

  assign mtime_o    = mtime_q;
  assign mtimecmp_o = cmp_q;
  assign mtip_o     = (mtime_q >= cmp_q);

endmodule

// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller: timer, software bit, edge-latched external
// lines, fixed-priority arbitration and a request held until ack or withdrawal.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned NUM_EXT  = 8,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_EXT-1:0] ext_irq,
  input  logic               mie_meie,
  input  logic               mie_mtie,
  input  logic               mie_msie,
  irq_ctrl_if.slave          bus
);

  logic [63:0]        mtime, mtimecmp;
  logic               mtip;
  logic               msip_q, msip_d;
  logic [NUM_EXT-1:0] ext_en_q, ext_en_d;
  logic [NUM_EXT-1:0] ext_pend_q, ext_pend_d;
  logic [NUM_EXT-1:0] ext_prev_q;
  logic [NUM_EXT-1:0] ext_w1c, ext_active;
  logic [4:0]         ext_id;
  logic               elig_mei, elig_msi, elig_mti, latched_ok;
  irq_state_e         state_q, state_d;
  logic               req_q, req_d;
  logic [31:0]        cause_q, cause_d;

  function automatic logic wr(input logic we, input logic [2:0] a, input logic [2:0] idx);
    return we && (a == idx);
  endfunction

  irq_mtimer #(.TICK_DIV(TICK_DIV)) u_mtimer (
    .clk           (clk),
    .rst           (rst),
    .mtime_lo_we   (wr(bus.reg_we, bus.reg_addr, REG_MTIME_LO)),
    .mtime_hi_we   (wr(bus.reg_we, bus.reg_addr, REG_MTIME_HI)),
    .mtimecmp_lo_we(wr(bus.reg_we, bus.reg_addr, REG_MTIMECMP_LO)),
    .mtimecmp_hi_we(wr(bus.reg_we, bus.reg_addr, REG_MTIMECMP_HI)),
    .wdata         (bus.reg_wdata),
    .mtime_o       (mtime),
    .mtimecmp_o    (mtimecmp),
    .mtip_o        (mtip)
  );

  // A new rising edge is OR-ed in after the W1C mask, so set beats clear.
  always_comb begin
    msip_d     = wr(bus.reg_we, bus.reg_addr, REG_MSIP) ? bus.reg_wdata[0] : msip_q;
    ext_en_d   = wr(bus.reg_we, bus.reg_addr, REG_EXT_EN) ? bus.reg_wdata[NUM_EXT-1:0] : ext_en_q;
    ext_w1c    = wr(bus.reg_we, bus.reg_addr, REG_EXT_PEND) ? bus.reg_wdata[NUM_EXT-1:0] : '0;
    ext_pend_d = (ext_pend_q & ~ext_w1c) | (ext_irq & ~ext_prev_q);
    ext_active = ext_pend_q & ext_en_q;
    ext_id     = '0;
    for (int i = int'(NUM_EXT) - 1; i >= 0; i--) begin
      if (ext_active[i]) ext_id = 5'(i);
    end
  end

  assign elig_mei   = (|ext_active) && mie_meie;
  assign elig_msi   = msip_q && mie_msie;
  assign elig_mti   = mtip && mie_mtie;
  assign latched_ok = ((cause_q == CAUSE_MEI) && elig_mei) ||
                      ((cause_q == CAUSE_MSI) && elig_msi) ||
                      ((cause_q == CAUSE_MTI) && elig_mti);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cause_d = cause_q;
    case (state_q)
      IDLE: if (elig_mei || elig_msi || elig_mti) begin
        state_d = REQ;
        req_d   = 1'b1;
        cause_d = elig_mei ? CAUSE_MEI : (elig_msi ? CAUSE_MSI : CAUSE_MTI);
      end
      REQ: if (bus.trap_ack) begin
        state_d = ACK;
        req_d   = 1'b0;
      end else if (!latched_ok) begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      msip_q     <= 1'b0;
      ext_en_q   <= '0;
      ext_pend_q <= '0;
      ext_prev_q <= '0;
      state_q    <= IDLE;
      req_q      <= 1'b0;
      cause_q    <= '0;
    end else begin
      msip_q     <= msip_d;
      ext_en_q   <= ext_en_d;
      ext_pend_q <= ext_pend_d;
      ext_prev_q <= ext_irq;
      state_q    <= state_d;
      req_q      <= req_d;
      cause_q    <= cause_d;
    end
  end

  always_comb begin
    bus.reg_rdata = '0;
    case (bus.reg_addr)
      REG_MTIME_LO:    bus.reg_rdata = mtime[31:0];
      REG_MTIME_HI:    bus.reg_rdata = mtime[63:32];
      REG_MTIMECMP_LO: bus.reg_rdata = mtimecmp[31:0];
      REG_MTIMECMP_HI: bus.reg_rdata = mtimecmp[63:32];
      REG_MSIP:        bus.reg_rdata = {31'd0, msip_q};
      REG_EXT_EN:      bus.reg_rdata = 32'(ext_en_q);
      REG_EXT_PEND:    bus.reg_rdata = 32'(ext_pend_q);
      default:         bus.reg_rdata = {|ext_active, 26'd0, ext_id};
    endcase
  end

  assign bus.interrupt_req   = req_q;
  assign bus.interrupt_cause = cause_q;

endmodule
